tdm_demux4: RTL



---
 rtl/tdm_demux4_if.sv | 39 +++
 rtl/tdm_demux4.sv | 104 ++++++++++
 2 files changed

// File: rtl/tdm_demux4_if.sv
// Bundle between the shared-line receiver (tdm_demux4) and whatever drives/consumes it.
// Optional `define TDM_ERR_CNT_EN adds the 8-bit err_cnt signal.
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             frame_sync;
    logic             din;
    logic [3:0]       slot_oh;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;
    logic [WIDTH-1:0] q3;
    // vld[i] is a one-cycle strobe with no back-pressure: q_i holds the new word from that cycle on.
    logic [3:0]       vld;
    logic             sync_err;
    logic             locked;
`ifdef TDM_ERR_CNT_EN
    logic [7:0]       err_cnt;

    modport master (
        output en, frame_sync, din,
        input  slot_oh, q0, q1, q2, q3, vld, sync_err, locked, err_cnt
    );
    modport slave (
        input  en, frame_sync, din,
        output slot_oh, q0, q1, q2, q3, vld, sync_err, locked, err_cnt
    );
`else
    modport master (
        output en, frame_sync, din,
        input  slot_oh, q0, q1, q2, q3, vld, sync_err, locked
    );
    modport slave (
        input  en, frame_sync, din,
        output slot_oh, q0, q1, q2, q3, vld, sync_err, locked
    );
`endif
endinterface

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: one bit per slot, four slots per frame, MSB-first WIDTH-bit words.
// Optional `define TDM_ERR_CNT_EN adds a saturating count of frame resynchronisations (err_cnt).
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    tdm_demux4_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       slot;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sreg [4];
    logic [WIDTH-1:0] q [4];
    logic [3:0]       vld_r;
    logic             sync_err_r;
    logic             lock_now;
    logic             resync;
    logic             capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_UNLOCKED;
        else        state <= state_nxt;
    end

    // Once locked the block free-runs; only reset drops alignment.
    always_comb begin
        state_nxt = state;
        if (state == ST_UNLOCKED && bus.en && bus.frame_sync) state_nxt = ST_LOCKED;
    end

    // The FSM state is published as 'locked'; slot_oh decodes registers only.
    always_comb begin
        bus.locked  = (state == ST_LOCKED);
        bus.slot_oh = '0;
        if (state == ST_LOCKED) bus.slot_oh[slot] = 1'b1;
        lock_now = bus.en && bus.frame_sync && (state == ST_UNLOCKED);
        resync   = bus.en && bus.frame_sync && (state == ST_LOCKED) && (slot != 2'd0);
        capture  = bus.en && (state == ST_LOCKED) && !resync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= 2'd0;
            bit_cnt    <= '0;
            vld_r      <= '0;
            sync_err_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sreg[i] <= '0;
                q[i]    <= '0;
            end
        end else begin
            vld_r      <= '0;
            sync_err_r <= 1'b0;
            if (lock_now) begin
                sreg[0] <= {sreg[0][WIDTH-2:0], bus.din};
                slot    <= 2'd1;
                bit_cnt <= '0;
            end else if (resync) begin
                // Restart the word period with this bit as channel 0's MSB; partial words are dropped.
                for (int i = 1; i < 4; i++) sreg[i] <= '0;
                sreg[0]    <= {{(WIDTH-1){1'b0}}, bus.din};
                slot       <= 2'd1;
                bit_cnt    <= '0;
                sync_err_r <= 1'b1;
            end else if (capture) begin
                sreg[slot] <= {sreg[slot][WIDTH-2:0], bus.din};
                slot       <= slot + 2'd1;
                if (slot == 2'd3) bit_cnt <= (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
                if (bit_cnt == CNT_MAX) begin
                    q[slot]     <= {sreg[slot][WIDTH-2:0], bus.din};
                    vld_r[slot] <= 1'b1;
                end
            end
        end
    end

    assign bus.q0       = q[0];
    assign bus.q1       = q[1];
    assign bus.q2       = q[2];
    assign bus.q3       = q[3];
    assign bus.vld      = vld_r;
    assign bus.sync_err = sync_err_r;

`ifdef TDM_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          err_cnt_r <= 8'h00;
        else if (resync && err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'h01;
    end

    assign bus.err_cnt = err_cnt_r;
`endif
endmodule
